// File: rtl/spi_daisy_port_if.sv
// Signal bundle for spi_daisy_port: raw SPI pins on one side, the core's
// result/config words on the other.
interface spi_daisy_port_if #(
  parameter int WIDTH = 32
);
  logic             sck_in;
  logic             sdi_in;
  logic             cs_n_in;
  logic             sdo_out;
  logic [WIDTH-1:0] result_data_in;
  logic [WIDTH-1:0] cfg_data_out;
  logic             cfg_valid_out;
  logic             busy_out;
  logic             frame_err_out;

  modport slave (
    input  sck_in, sdi_in, cs_n_in, result_data_in,
    output sdo_out, cfg_data_out, cfg_valid_out, busy_out, frame_err_out
  );

  modport master (
    output sck_in, sdi_in, cs_n_in, result_data_in,
    input  sdo_out, cfg_data_out, cfg_valid_out, busy_out, frame_err_out
  );
endinterface

// File: rtl/spi_daisy_port.sv
// Core-clock daisy-chain SPI slave: syncs the pins, shifts result out / config in.
// Define SPI_DAISY_FRAME_CHECK_EN to enforce multiple-of-WIDTH frame lengths.
module spi_daisy_port #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  spi_daisy_port_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_sckSync;
  logic [1:0]       r_sdiSync;
  logic [2:0]       r_csnSync;
  logic [1:0]       r_settleCnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_cfgData;
  logic             r_cfgValid;
  logic [CNT_W-1:0] r_bitIdx;
  logic             r_wordSeen;
  logic             w_sckRise;
  logic             w_csnFall;
  logic             w_csnRise;
  logic             w_sdi;
  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic             w_frameOk;
  logic             w_busy;

  // Stage 2 is the synchronised value; stage 3 is only for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sckSync   <= 3'b000;
      r_sdiSync   <= 2'b00;
      r_csnSync   <= 3'b111;
      r_settleCnt <= 2'd0;
    end else begin
      r_sckSync <= {r_sckSync[1:0], bus.sck_in};
      r_sdiSync <= {r_sdiSync[0], bus.sdi_in};
      r_csnSync <= {r_csnSync[1:0], bus.cs_n_in};
      if (r_settleCnt != 2'd3) begin
        r_settleCnt <= r_settleCnt + 2'd1;
      end
    end
  end

  assign w_sckRise = r_sckSync[1] & ~r_sckSync[2];
  assign w_csnFall = ~r_csnSync[1] & r_csnSync[2];
  assign w_csnRise = r_csnSync[1] & ~r_csnSync[2];
  assign w_sdi     = r_sdiSync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The cs_n sync stages reset to 1, so WAIT_IDLE waits until they hold real pin samples.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT_IDLE: if (r_settleCnt == 2'd3 && r_csnSync[2:1] == 2'b11) w_nextState = IDLE;
      IDLE:      if (w_csnFall) w_nextState = SHIFT;
      SHIFT:     if (w_csnRise) w_nextState = DONE;
      DONE:      w_nextState = IDLE;
      default:   w_nextState = WAIT_IDLE;
    endcase
  end

  assign w_load  = (r_state == IDLE) && w_csnFall;
  assign w_shift = (r_state == SHIFT) && w_sckRise && !w_csnRise;
  assign w_done  = (r_state == DONE);
  assign w_busy  = (r_state == SHIFT) || (r_state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg     <= '0;
      r_bitIdx   <= '0;
      r_wordSeen <= 1'b0;
    end else if (w_load) begin
      r_sreg     <= bus.result_data_in;
      r_bitIdx   <= '0;
      r_wordSeen <= 1'b0;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], w_sdi};
      if (r_bitIdx == CNT_W'(WIDTH - 1)) begin
        r_bitIdx   <= '0;
        r_wordSeen <= 1'b1;
      end else begin
        r_bitIdx <= r_bitIdx + CNT_W'(1);
      end
    end
  end

`ifdef SPI_DAISY_FRAME_CHECK_EN
  logic r_frameErr;

  assign w_frameOk = r_wordSeen && (r_bitIdx == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frameErr <= 1'b0;
    end else if (w_done && !w_frameOk) begin
      r_frameErr <= 1'b1;
    end
  end

  assign bus.frame_err_out = r_frameErr;
`else
  // Without the length check any frame that saw at least one sck edge is accepted.
  assign w_frameOk = r_wordSeen || (r_bitIdx != '0);
  assign bus.frame_err_out = 1'b0;
`endif

  // Valid pulse and new data appear together in the cycle after DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfgData  <= '0;
      r_cfgValid <= 1'b0;
    end else begin
      r_cfgValid <= w_done && w_frameOk;
      if (w_done && w_frameOk) begin
        r_cfgData <= r_sreg;
      end
    end
  end

  assign bus.sdo_out       = w_busy & r_sreg[WIDTH-1];
  assign bus.cfg_data_out  = r_cfgData;
  assign bus.cfg_valid_out = r_cfgValid;
  assign bus.busy_out      = w_busy;

endmodule

// File: tb/tb_spi_daisy_port.sv
// Randomised and directed bench for spi_daisy_port; the reference model treats
// the frame as one bit stream {result word, host bits} and takes the last 32.
module tb_spi_daisy_port;

  localparam int  W    = 32;
  localparam time HALF = 60ns;

  logic clk;
  logic reset;

  spi_daisy_port_if #(.WIDTH(W)) bus ();

  spi_daisy_port #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5ns clk = ~clk;

  int          checks     = 0;
  int          failures   = 0;
  int          pulseCount = 0;
  int          busyCount  = 0;
  logic [W-1:0] lastCfg   = '0;
  logic [W-1:0] cfgModel  = '0;
  bit          errModel   = 1'b0;
  bit          txBits[$];

  always @(negedge clk) begin
    if (bus.cfg_valid_out === 1'b1) begin
      pulseCount++;
      lastCfg = bus.cfg_data_out;
    end
    if (bus.busy_out === 1'b1) busyCount++;
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadWord(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) txBits.push_back(w[i]);
  endtask

  task automatic clockBit(input bit b, output bit sdoBit);
    bus.sdi_in = b;
    #HALF;
    sdoBit = bus.sdo_out;
    bus.sck_in = 1'b1;
    #HALF;
    bus.sck_in = 1'b0;
  endtask

  // One complete frame from the host; result_data_in is scrambled after the start.
  task automatic applyStimulus(input string tag, input logic [W-1:0] result);
    bit stream[$];
    bit sdoBit;
    bit valid;
    int n;
    int p0;
    int b0;
    int mism;
    logic [W-1:0] expCfg;
    n = txBits.size();
    stream = {};
    for (int i = W - 1; i >= 0; i--) stream.push_back(result[i]);
    foreach (txBits[i]) stream.push_back(txBits[i]);
    p0 = pulseCount;
    b0 = busyCount;
    mism = 0;
    bus.result_data_in = result;
    bus.cs_n_in = 1'b0;
    repeat (6) @(posedge clk);
    #1ns;
    bus.result_data_in = $urandom();
    for (int i = 0; i < n; i++) begin
      clockBit(txBits[i], sdoBit);
      if (sdoBit !== stream[i]) mism++;
    end
    #HALF;
    bus.cs_n_in = 1'b1;
    repeat (12) @(posedge clk);
    #1ns;
`ifdef SPI_DAISY_FRAME_CHECK_EN
    valid = (n > 0) && (n % W == 0);
    if (!valid) errModel = 1'b1;
`else
    valid = (n > 0);
`endif
    if (valid) begin
      for (int k = 0; k < W; k++) expCfg[W-1-k] = stream[stream.size() - W + k];
      cfgModel = expCfg;
    end
    checkOutput({tag, "_pulses"}, W'(pulseCount - p0), valid ? W'(1) : W'(0));
    checkOutput({tag, "_cfg"}, bus.cfg_data_out, cfgModel);
    if (valid) checkOutput({tag, "_pulse_data"}, lastCfg, cfgModel);
    checkOutput({tag, "_err"}, W'(bus.frame_err_out), W'(errModel));
    if (n > 0) checkOutput({tag, "_sdo_mismatches"}, W'(mism), W'(0));
    checkOutput({tag, "_busy_seen"}, W'(busyCount > b0), W'(1));
    checkOutput({tag, "_sdo_idle"}, W'(bus.sdo_out), W'(0));
    txBits = {};
  endtask

  initial begin
    bit dummy;
    int p0;
    int b0;
    int sel;
    int extra;

    reset = 1'b1;
    bus.sck_in = 1'b0;
    bus.sdi_in = 1'b0;
    bus.cs_n_in = 1'b1;
    bus.result_data_in = '0;
    repeat (3) @(posedge clk);
    #1ns;
    checkOutput("reset_busy", W'(bus.busy_out), W'(0));
    checkOutput("reset_sdo", W'(bus.sdo_out), W'(0));
    checkOutput("reset_cfg", bus.cfg_data_out, W'(0));
    checkOutput("reset_valid", W'(bus.cfg_valid_out), W'(0));
    checkOutput("reset_err", W'(bus.frame_err_out), W'(0));

    // Frame already running when reset releases must be ignored.
    bus.cs_n_in = 1'b0;
    repeat (3) @(posedge clk);
    #1ns;
    reset = 1'b0;
    p0 = pulseCount;
    b0 = busyCount;
    repeat (4) @(posedge clk);
    #1ns;
    for (int i = 0; i < W; i++) clockBit(1'($urandom()), dummy);
    #HALF;
    bus.cs_n_in = 1'b1;
    repeat (12) @(posedge clk);
    #1ns;
    checkOutput("inprogress_pulses", W'(pulseCount - p0), W'(0));
    checkOutput("inprogress_busy", W'(busyCount - b0), W'(0));

    loadWord(32'hDEAD_BEEF);
    applyStimulus("basic", 32'h8000_1234);
    checkOutput("basic_cfg_const", bus.cfg_data_out, 32'hDEAD_BEEF);

    loadWord(32'h1111_1111);
    loadWord(32'h2222_2222);
    applyStimulus("chain2", $urandom());
    checkOutput("chain2_cfg_const", bus.cfg_data_out, 32'h2222_2222);

    for (int i = 0; i < W - 1; i++) txBits.push_back(1'b1);
    applyStimulus("short31", 32'h0000_0000);

    loadWord($urandom());
    applyStimulus("after_short", $urandom());

    applyStimulus("zero_edges", $urandom());

    for (int f = 0; f < 6; f++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 3) begin
        extra = int'($urandom_range(1, 40));
        for (int i = 0; i < extra; i++) txBits.push_back(1'($urandom()));
      end else begin
        for (int j = 0; j <= sel; j++) loadWord($urandom());
      end
      applyStimulus($sformatf("rand%0d", f), $urandom());
    end

    // Reset in the middle of a frame.
    bus.result_data_in = $urandom();
    bus.cs_n_in = 1'b0;
    repeat (6) @(posedge clk);
    #1ns;
    for (int i = 0; i < 10; i++) clockBit(1'($urandom()), dummy);
    reset = 1'b1;
    #1ns;
    cfgModel = '0;
    errModel = 1'b0;
    checkOutput("midreset_busy", W'(bus.busy_out), W'(0));
    checkOutput("midreset_sdo", W'(bus.sdo_out), W'(0));
    checkOutput("midreset_cfg", bus.cfg_data_out, cfgModel);
    checkOutput("midreset_valid", W'(bus.cfg_valid_out), W'(0));
    checkOutput("midreset_err", W'(bus.frame_err_out), W'(errModel));
    repeat (3) @(posedge clk);
    #1ns;
    reset = 1'b0;
    p0 = pulseCount;
    b0 = busyCount;
    for (int i = 0; i < W - 10; i++) clockBit(1'($urandom()), dummy);
    #HALF;
    bus.cs_n_in = 1'b1;
    repeat (12) @(posedge clk);
    #1ns;
    checkOutput("midreset_after_pulses", W'(pulseCount - p0), W'(0));
    checkOutput("midreset_after_busy", W'(busyCount - b0), W'(0));
    checkOutput("midreset_after_cfg", bus.cfg_data_out, cfgModel);

    loadWord($urandom());
    applyStimulus("post_reset", $urandom());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
